// File: rtl/reversing_bits_pkg.sv
// ---------------------------------------------------------------------------
// reversing_bits_pkg
//   Shared constants and helpers for the bit-order reversal stage.
//   - DEFAULT_DATA_WIDTH : default word width of the stage.
//   - MAX_REVERSE_WIDTH  : widest word reverse_bits() can handle.
//   - reverse_bits()     : mirrors the low 'width' bits of a word
//                          (bit i of the result = bit width-1-i of d).
//                          Bits at and above 'width' are returned as zero.
// ---------------------------------------------------------------------------
package reversing_bits_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int MAX_REVERSE_WIDTH  = 64;

    // A package function cannot take a type parameter, so it works on the
    // widest supported word and takes the live width as an argument.
    function automatic logic [MAX_REVERSE_WIDTH-1:0] reverse_bits(
        input logic [MAX_REVERSE_WIDTH-1:0] d,
        input int                           width
    );
        logic [MAX_REVERSE_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_REVERSE_WIDTH; i++) begin
            if (i < width) begin
                r[i] = d[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse_comb.sv
// ---------------------------------------------------------------------------
// bit_reverse_comb
//   Purely combinational bit mirror: data_out[i] = data_in[DATA_WIDTH-1-i].
//   Pure rewiring, so an unknown input bit only affects its mirrored output.
//   Ports:
//     data_in  [DATA_WIDTH-1:0] : word to mirror
//     data_out [DATA_WIDTH-1:0] : mirrored word
// ---------------------------------------------------------------------------
module bit_reverse_comb
    import reversing_bits_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    // One assign per bit keeps each output bit tied to exactly one input bit.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mirror
            assign data_out[gi] = data_in[DATA_WIDTH-1-gi];
        end
    endgenerate

endmodule

// File: rtl/reversing_bits.sv
// ---------------------------------------------------------------------------
// reversing_bits
//   Registered bit-order reversal stage with a travelling valid flag.
//   Latency 1 clock, throughput 1 word per clock, no backpressure.
//   Ports:
//     clk       : system clock, rising edge
//     rst       : asynchronous active-high reset, clears both outputs
//     valid_in  : data_in carries a word this cycle
//     data_in   : word to reverse
//     valid_out : data_out carries a reversed word this cycle
//     data_out  : bit-reversed copy of the last accepted data_in
// ---------------------------------------------------------------------------
module reversing_bits
    import reversing_bits_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] data_rev_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  valid_out_reg;

    bit_reverse_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mirror (
        .data_in  (data_in),
        .data_out (data_rev_next)
    );

    // Data only loads on a valid word; during idle cycles the last reversed
    // word stays visible and only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_reg <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            valid_out_reg <= valid_in;
            if (valid_in) begin
                data_out_reg <= data_rev_next;
            end
        end
    end

    assign valid_out = valid_out_reg;
    assign data_out  = data_out_reg;

endmodule

// File: tb/tb_reversing_bits.sv
// ---------------------------------------------------------------------------
// tb_reversing_bits
//   Self-checking bench for reversing_bits at widths 8, 1, 5 and 16.
//   Inputs change 1 ns after a rising edge; outputs are compared 1 ns after
//   the edge that should have produced them.
// ---------------------------------------------------------------------------
module tb_reversing_bits;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v8,  vo8;   logic [7:0]  d8,  do8;
    logic        v1,  vo1;   logic [0:0]  d1,  do1;
    logic        v5,  vo5;   logic [4:0]  d5,  do5;
    logic        v16, vo16;  logic [15:0] d16, do16;

    reversing_bits dut8 (
        .clk(clk), .rst(rst), .valid_in(v8), .data_in(d8),
        .valid_out(vo8), .data_out(do8));
    reversing_bits #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(v1), .data_in(d1),
        .valid_out(vo1), .data_out(do1));
    reversing_bits #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .valid_in(v5), .data_in(d5),
        .valid_out(vo5), .data_out(do5));
    reversing_bits #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .valid_in(v16), .data_in(d16),
        .valid_out(vo16), .data_out(do16));

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural expectation for every instance.
    logic        ev8,  ev1,  ev5,  ev16;
    logic [31:0] ed8,  ed1,  ed5,  ed16;

    // Reversal by repeated halving: peel the LSB off x, push it onto r.
    function automatic logic [31:0] ref_rev(input logic [31:0] x, input int w);
        logic [31:0] r;
        logic [31:0] t;
        r = 32'd0;
        t = x;
        for (int i = 0; i < w; i++) begin
            r = r * 2 + (t % 2);
            t = t / 2;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            ev8 = 0; ev1 = 0; ev5 = 0; ev16 = 0;
            ed8 = 0; ed1 = 0; ed5 = 0; ed16 = 0;
        end else begin
            ev8 = v8;   if (v8)  ed8  = ref_rev(32'(d8), 8);
            ev1 = v1;   if (v1)  ed1  = ref_rev(32'(d1), 1);
            ev5 = v5;   if (v5)  ed5  = ref_rev(32'(d5), 5);
            ev16 = v16; if (v16) ed16 = ref_rev(32'(d16), 16);
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " w8 valid"},  32'(vo8),  32'(ev8));
        chk({tag, " w8 data"},   32'(do8),  ed8);
        chk({tag, " w1 valid"},  32'(vo1),  32'(ev1));
        chk({tag, " w1 data"},   32'(do1),  ed1);
        chk({tag, " w5 valid"},  32'(vo5),  32'(ev5));
        chk({tag, " w5 data"},   32'(do5),  ed5);
        chk({tag, " w16 valid"}, 32'(vo16), 32'(ev16));
        chk({tag, " w16 data"},  32'(do16), ed16);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    localparam int NTBL = 15;
    vec_t tbl [NTBL];

    initial begin
        // Single words separated by idle cycles, then a back-to-back stream,
        // an idle gap with changing data, and palindromes.
        tbl[0]  = '{1'b1, 8'h27, 1'b1, 8'hE4};
        tbl[1]  = '{1'b0, 8'hA5, 1'b0, 8'hE4};
        tbl[2]  = '{1'b1, 8'h01, 1'b1, 8'h80};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h80};
        tbl[4]  = '{1'b1, 8'h94, 1'b1, 8'h29};
        tbl[5]  = '{1'b0, 8'h5A, 1'b0, 8'h29};
        tbl[6]  = '{1'b1, 8'h05, 1'b1, 8'hA0};
        tbl[7]  = '{1'b1, 8'h27, 1'b1, 8'hE4};
        tbl[8]  = '{1'b1, 8'h01, 1'b1, 8'h80};
        tbl[9]  = '{1'b1, 8'h94, 1'b1, 8'h29};
        tbl[10] = '{1'b1, 8'h05, 1'b1, 8'hA0};
        tbl[11] = '{1'b0, 8'hA5, 1'b0, 8'hA0};
        tbl[12] = '{1'b1, 8'h81, 1'b1, 8'h81};
        tbl[13] = '{1'b1, 8'h00, 1'b1, 8'h00};
        tbl[14] = '{1'b1, 8'hFF, 1'b1, 8'hFF};

        // Reset with a valid all-ones word pending on every instance.
        rst = 1'b1;
        v8 = 1; d8 = 8'hFF; v1 = 1; d1 = 1'b1;
        v5 = 1; d5 = 5'h1F; v16 = 1; d16 = 16'hFFFF;
        ev8 = 0; ev1 = 0; ev5 = 0; ev16 = 0;
        ed8 = 0; ed1 = 0; ed5 = 0; ed16 = 0;
        #1;
        chk("reset w8 valid t0", 32'(vo8), 32'd0);
        chk("reset w8 data t0",  32'(do8), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset w8 valid held", 32'(vo8), 32'd0);
            chk("reset w8 data held",  32'(do8), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("first capture w8 valid", 32'(vo8), 32'd1);
        chk("first capture w8 data",  32'(do8), 32'hFF);
        check_all("first capture");

        // Directed 8-bit table; the other widths idle.
        v1 = 0; v5 = 0; v16 = 0;
        for (int i = 0; i < NTBL; i++) begin
            v8 = tbl[i].v;
            d8 = tbl[i].d;
            step();
            chk($sformatf("tbl[%0d] valid", i), 32'(vo8), 32'(tbl[i].ev));
            chk($sformatf("tbl[%0d] data in=%h", i, tbl[i].d), 32'(do8), 32'(tbl[i].ed));
        end

        // Width sweep, fixed vectors.
        v8 = 0;
        v1 = 1; d1 = 1'b1;
        v5 = 1; d5 = 5'b11010;
        v16 = 1; d16 = 16'h0001;
        step();
        chk("w1 1->1",           32'(do1),  32'd1);
        chk("w5 11010->01011",   32'(do5),  32'b01011);
        chk("w16 0001->8000",    32'(do16), 32'h8000);
        chk("w16 valid",         32'(vo16), 32'd1);
        check_all("sweep");

        // Asynchronous reset between edges, with a word in flight.
        v8 = 1; d8 = 8'h3C;
        #3 rst = 1'b1;
        #1;
        chk("async rst w8 valid immediate", 32'(vo8),  32'd0);
        chk("async rst w8 data immediate",  32'(do8),  32'd0);
        chk("async rst w16 data immediate", 32'(do16), 32'd0);
        chk("async rst w5 data immediate",  32'(do5),  32'd0);
        step();
        check_all("in reset");
        rst = 1'b0;
        v8 = 0; v1 = 0; v5 = 0; v16 = 0;
        step();
        chk("pending word dropped valid", 32'(vo8), 32'd0);
        chk("pending word dropped data",  32'(do8), 32'd0);

        // Randomized traffic on all widths against the model.
        for (int i = 0; i < 300; i++) begin
            v8  = 1'($urandom_range(0, 1));  d8  = 8'($urandom);
            v1  = 1'($urandom_range(0, 1));  d1  = 1'($urandom);
            v5  = 1'($urandom_range(0, 1));  d5  = 5'($urandom);
            v16 = 1'($urandom_range(0, 1));  d16 = 16'($urandom);
            step();
            check_all($sformatf("rand %0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
